// File: rtl/rv_decode_pkg.sv
// Shared RISC-V decode definitions: opcodes, ALU operation codes and the
// control/fault bundles carried in the ID/EX register.
package rv_decode_pkg;

  localparam int REG_AW = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch;
  } ctrl_t;

  typedef struct packed {
    logic inv_op;
    logic inv_func;
    logic inv_reg;
  } fault_t;

  function automatic logic reg_out_of_range(input logic [REG_AW-1:0] r, input int num_regs);
    return int'(r) >= num_regs;
  endfunction

endpackage

// File: rtl/rv_decoder.sv
// Combinational RV32I/RV64I/RV32E decoder: control bits, sign-extended immediate,
// fault flags and which source registers the instruction actually reads.
module rv_decoder
  import rv_decode_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int NUM_REGS = 32
) (
  input  logic [31:0]     i_instr,
  output ctrl_t           o_ctrl,
  output logic [XLEN-1:0] o_imm,
  output fault_t          o_fault,
  output logic            o_use_rs1,
  output logic            o_use_rs2
);

  localparam logic       IS_RV32      = (XLEN == 32);
  localparam logic [2:0] LOAD_F3_MAX  = IS_RV32 ? 3'd2 : 3'd3;

  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic [6:0]        w_funct7;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic [REG_AW-1:0] w_rd;
  logic [XLEN-1:0]   w_imm_i;
  logic [XLEN-1:0]   w_imm_s;
  logic [XLEN-1:0]   w_imm_b;

  ctrl_t             w_ctrl;
  logic [XLEN-1:0]   w_imm;
  logic              w_inv_op;
  logic              w_inv_func;
  logic              w_inv_reg;
  logic              w_use_rs1;
  logic              w_use_rs2;
  logic              w_use_rd;
  logic              w_fault;

  assign w_opcode = i_instr[6:0];
  assign w_rd     = i_instr[11:7];
  assign w_funct3 = i_instr[14:12];
  assign w_rs1    = i_instr[19:15];
  assign w_rs2    = i_instr[24:20];
  assign w_funct7 = i_instr[31:25];

  assign w_imm_i = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                    i_instr[30:25], i_instr[11:8], 1'b0};

  always_comb begin
    w_ctrl     = '0;
    w_imm      = '0;
    w_inv_op   = 1'b0;
    w_inv_func = 1'b0;
    w_use_rs1  = 1'b1;
    w_use_rs2  = 1'b0;
    w_use_rd   = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_ctrl.reg_write = 1'b1;
        w_use_rs2        = 1'b1;
        w_use_rd         = 1'b1;
        case ({w_funct7, w_funct3})
          10'b0000000_000: w_ctrl.alu_ctrl = ALU_ADD;
          10'b0100000_000: w_ctrl.alu_ctrl = ALU_SUB;
          10'b0000000_001: w_ctrl.alu_ctrl = ALU_SLL;
          10'b0000000_010: w_ctrl.alu_ctrl = ALU_SLT;
          10'b0000000_100: w_ctrl.alu_ctrl = ALU_XOR;
          10'b0000000_101: w_ctrl.alu_ctrl = ALU_SRL;
          10'b0100000_101: w_ctrl.alu_ctrl = ALU_SRA;
          10'b0000000_110: w_ctrl.alu_ctrl = ALU_OR;
          10'b0000000_111: w_ctrl.alu_ctrl = ALU_AND;
          default:         w_inv_func      = 1'b1;
        endcase
      end
      OP_IALU: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_use_rd         = 1'b1;
        w_imm            = w_imm_i;
        case (w_funct3)
          3'b000: w_ctrl.alu_ctrl = ALU_ADD;
          3'b010: w_ctrl.alu_ctrl = ALU_SLT;
          3'b100: w_ctrl.alu_ctrl = ALU_XOR;
          3'b110: w_ctrl.alu_ctrl = ALU_OR;
          3'b111: w_ctrl.alu_ctrl = ALU_AND;
          3'b001: begin
            w_ctrl.alu_ctrl = ALU_SLL;
            w_inv_func      = (i_instr[31:26] != 6'b000000) || (IS_RV32 && i_instr[25]);
          end
          3'b101: begin
            // shamt is 6 bits on RV64; bit 25 belongs to the shift amount there
            if (i_instr[31:26] == 6'b000000)      w_ctrl.alu_ctrl = ALU_SRL;
            else if (i_instr[31:26] == 6'b010000) w_ctrl.alu_ctrl = ALU_SRA;
            else                                  w_inv_func      = 1'b1;
            if (IS_RV32 && i_instr[25])           w_inv_func      = 1'b1;
          end
          default: w_inv_func = 1'b1;
        endcase
      end
      OP_LOAD: begin
        w_ctrl.alu_ctrl   = ALU_ADD;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_use_rd          = 1'b1;
        w_imm             = w_imm_i;
        w_inv_func        = (w_funct3 > LOAD_F3_MAX);
      end
      OP_STORE: begin
        w_ctrl.alu_ctrl  = ALU_ADD;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
        w_use_rs2        = 1'b1;
        w_imm            = w_imm_s;
      end
      OP_BRANCH: begin
        w_ctrl.alu_ctrl = ALU_SUB;
        w_ctrl.branch   = 1'b1;
        w_use_rs2       = 1'b1;
        w_imm           = w_imm_b;
      end
      default: w_inv_op = 1'b1;
    endcase
  end

  assign w_inv_reg = (w_use_rs1 && reg_out_of_range(w_rs1, NUM_REGS)) ||
                     (w_use_rs2 && reg_out_of_range(w_rs2, NUM_REGS)) ||
                     (w_use_rd  && reg_out_of_range(w_rd,  NUM_REGS));

  assign w_fault = w_inv_op || w_inv_func || w_inv_reg;

  // Faulting instructions still reach EX, but must not cause architectural side effects
  always_comb begin
    o_ctrl = w_ctrl;
    if (w_fault) begin
      o_ctrl.reg_write = 1'b0;
      o_ctrl.mem_read  = 1'b0;
      o_ctrl.mem_write = 1'b0;
      o_ctrl.branch    = 1'b0;
    end
  end

  assign o_imm            = w_imm;
  assign o_fault.inv_op   = w_inv_op;
  assign o_fault.inv_func = w_inv_func;
  assign o_fault.inv_reg  = w_inv_reg;
  assign o_use_rs1        = w_use_rs1;
  assign o_use_rs2        = w_use_rs2;

endmodule

// File: rtl/id_stage_pipe.sv
// Registered decode stage: one cycle from acceptance to ex_*, 1 instr/cycle; if_ready
// drops on EX backpressure, load-use hazard (bubble inserted) or flush.
module id_stage_pipe
  import rv_decode_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [31:0]       if_instr,
  input  logic [XLEN-1:0]   if_pc,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_pc,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [XLEN-1:0]   ex_imm,
  output logic [3:0]        ex_alu_ctrl,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_inv_op,
  output logic              ex_inv_func,
  output logic              ex_inv_reg
);

  ctrl_t             w_ctrl;
  logic [XLEN-1:0]   w_imm;
  fault_t            w_fault;
  logic              w_use_rs1;
  logic              w_use_rs2;
  logic              w_advance;
  logic              w_hazard;
  logic              w_load;

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;
  logic [XLEN-1:0]   r_imm;
  ctrl_t             r_ctrl;
  fault_t            r_fault;

  rv_decoder #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_decoder (
    .i_instr   (if_instr),
    .o_ctrl    (w_ctrl),
    .o_imm     (w_imm),
    .o_fault   (w_fault),
    .o_use_rs1 (w_use_rs1),
    .o_use_rs2 (w_use_rs2)
  );

  assign w_advance = !r_valid || ex_ready;

  assign w_hazard = r_valid && r_ctrl.mem_read && (r_rd != '0) &&
                    ((w_use_rs1 && (if_instr[19:15] == r_rd)) ||
                     (w_use_rs2 && (if_instr[24:20] == r_rd)));

  assign if_ready = w_advance && !w_hazard && !flush;
  assign w_load   = if_valid && if_ready;

  // A hazard with ex_ready high advances with w_load=0, which is the bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_imm   <= '0;
      r_ctrl  <= '0;
      r_fault <= '0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_advance) begin
        r_valid <= w_load;
      end
      if (w_load) begin
        r_pc    <= if_pc;
        r_rs1   <= if_instr[19:15];
        r_rs2   <= if_instr[24:20];
        r_rd    <= if_instr[11:7];
        r_imm   <= w_imm;
        r_ctrl  <= w_ctrl;
        r_fault <= w_fault;
      end
    end
  end

  assign ex_valid      = r_valid;
  assign ex_pc         = r_pc;
  assign ex_rs1        = r_rs1;
  assign ex_rs2        = r_rs2;
  assign ex_rd         = r_rd;
  assign ex_imm        = r_imm;
  assign ex_alu_ctrl   = r_ctrl.alu_ctrl;
  assign ex_alu_src    = r_ctrl.alu_src;
  assign ex_reg_write  = r_ctrl.reg_write;
  assign ex_mem_read   = r_ctrl.mem_read;
  assign ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign ex_mem_write  = r_ctrl.mem_write;
  assign ex_branch     = r_ctrl.branch;
  assign ex_inv_op     = r_fault.inv_op;
  assign ex_inv_func   = r_fault.inv_func;
  assign ex_inv_reg    = r_fault.inv_reg;

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Registered instruction-decode stage for the RISC-V pipeline. It decodes one 32-bit instruction per cycle into register addresses, a sign-extended immediate, ALU control and datapath control bits, and holds the result in an ID/EX pipeline register. The stage is parametrised in XLEN and architectural register count (RV32I/RV64I/RV32E). It has a valid/ready handshake on both sides, load-use hazard stalling with bubble insertion, synchronous flush, and decode-fault flags that travel with the instruction.

## Interface
- XLEN, 64, datapath and immediate width (32 or 64)
- NUM_REGS, 32, architectural registers (32, or 16 for RV32E); REG_AW = 5 always
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  stage accepts the instruction this cycle
- if_instr  in  32  instruction word
- if_pc  in  XLEN  instruction address
- flush  in  1  synchronous kill of the stage contents
- ex_valid  out  1  ID/EX register holds a valid instruction
- ex_ready  in  1  EX consumes the ID/EX register this cycle
- ex_pc  out  XLEN  registered PC
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered register addresses
- ex_imm  out  XLEN  sign-extended immediate
- ex_alu_ctrl  out  4  ALU operation
- ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_branch  out  1 each  control bits
- ex_inv_op, ex_inv_func, ex_inv_reg  out  1 each  decode-fault flags

## Operation
- Supported opcodes:
  - R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
  - Any other opcode sets inv_op.
- Immediates:
  - I-type: instr[31:20]. S-type: {[31:25],[11:7]}. B-type: {[31],[7],[30:25],[11:8],0}.
  - R-type immediate is 0.
  - All immediates are sign-extended to XLEN.
- ALU codes:
  - AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000.
  - LOAD and STORE use ADD. BRANCH uses SUB.
  - Undefined funct3/funct7 for R or I-ALU sets inv_func.
  - LOAD funct3 > 3 (XLEN=32: > 2) sets inv_func.
  - For XLEN=32, I-ALU shifts with instr[25]=1 set inv_func.
- inv_reg is set when any used register field is ≥ NUM_REGS.
- Any inv_* flag forces reg_write, mem_read, mem_write and branch to 0. The instruction still flows to EX with its flags so EX can trap.
- Control-bit table:
  - R: reg_write.
  - I-ALU: reg_write, alu_src.
  - LOAD: reg_write, alu_src, mem_read, mem_to_reg.
  - STORE: alu_src, mem_write.
  - BRANCH: branch.
- Register advance: the ID/EX register advances when (!ex_valid || ex_ready).
- Hazard:
  - Asserted when ex_valid && ex_mem_read && ex_rd≠0 && ex_rd matches a source the incoming instruction uses. The sources used are rs1 for all opcodes, and rs2 for R/STORE/BRANCH only.
  - During hazard, if_ready=0.
  - If ex_ready is also high, the register loads a bubble (ex_valid←0). Otherwise it holds.
- if_ready = advance && !hazard && !flush.
- flush has priority over everything: ex_valid←0 next edge and if_ready=0 that cycle. Payload regs may keep stale values.

## Timing
- Latency: accepted at edge N, the instruction appears on ex_* after edge N; throughput 1/cycle.
- Reset values:
  - ex_valid=0.
  - All ex_* payload outputs are 0.
  - if_ready reflects combinational state, which is 1 after reset when flush=0.
- Backpressure (ex_valid && !ex_ready): all ex_* hold stable; if_ready=0.
- Load-use: the dependent instruction is accepted one cycle after the load leaves, giving exactly one bubble.
- Reset mid-stall: the stage returns to empty immediately.
- Simultaneous flush and handshake: flush wins; the EX handshake of the current contents still completes.

## Structure
- rv_decode_pkg holds the opcode constants, ALU code constants and the control-bit struct.
- Sub-module rv_decoder is purely combinational. It takes instruction in and returns control, immediate, flags and source-use bits.
- id_stage_pipe owns the handshake, hazard logic and ID/EX register.

## Test plan
- Single instruction: add x3,x1,x2 (0x002081B3) → next cycle ex_rd=3, rs1=1, rs2=2, alu_ctrl=0010, reg_write=1, imm=0.
- Negative immediate: addi x1,x0,-1 (0xFFF00093), XLEN=64 → ex_imm=0xFFFF_FFFF_FFFF_FFFF, alu_src=1.
- Load-use: ld x5,0(x1) (0x0000B283) then add x6,x5,x5 (0x00528333), ex_ready=1 → the add is held for one cycle, ex_valid shows 1,0,1.
- Backpressure and flush: ex_ready=0 for 3 cycles → outputs stable and if_ready=0. flush on cycle 2 → ex_valid=0 next cycle.
- Illegal opcode: 0x0000007F → ex_inv_op=1, reg_write=0, mem_write=0.
- RV32E: NUM_REGS=16, add x17,x1,x2 → ex_inv_reg=1, reg_write=0.
